// File: rtl/sn74hc194_shift.sv
// 4-bit bidirectional universal shift register, SN74HC194 function and DIP pinout.
// Define HC194_PWR_PINS_EN to add constant GND (pin8) / VCC (pin16) outputs.
module sn74hc194_shift #(
    parameter logic [3:0] CLR_VALUE = 4'b0000
) (
    input  logic pin11,
    input  logic pin1,
    input  logic pin2,
    input  logic pin3,
    input  logic pin4,
    input  logic pin5,
    input  logic pin6,
    input  logic pin7,
    input  logic pin9,
    input  logic pin10,
    output logic pin15,
    output logic pin14,
    output logic pin13,
    output logic pin12
`ifdef HC194_PWR_PINS_EN
    ,
    output logic pin8,
    output logic pin16
`endif
);

    // q_q[3] is QA, q_q[0] is QD.
    logic [3:0] q_q;
    logic [3:0] q_d;
    logic [1:0] mode;

    assign mode = {pin10, pin9};

    always_comb begin
        q_d = q_q;
        case (mode)
            2'b01:   q_d = {pin2, q_q[3:1]};
            2'b10:   q_d = {q_q[2:0], pin7};
            2'b11:   q_d = {pin3, pin4, pin5, pin6};
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge pin11 or negedge pin1) begin
        if (!pin1) begin
            q_q <= CLR_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign pin15 = q_q[3];
    assign pin14 = q_q[2];
    assign pin13 = q_q[1];
    assign pin12 = q_q[0];

`ifdef HC194_PWR_PINS_EN
    assign pin8  = 1'b0;
    assign pin16 = 1'b1;
`endif

endmodule

// File: tb/tb_sn74hc194_shift.sv
// Directed bench for sn74hc194_shift: behavioural model compared every cycle
// plus literal expectations from the datasheet function table.
module tb_sn74hc194_shift;

    localparam logic [3:0] CLR = 4'b0000;

    logic pin11 = 1'b0;
    logic pin1  = 1'b0;
    logic pin2  = 1'b0;
    logic pin3  = 1'b0;
    logic pin4  = 1'b0;
    logic pin5  = 1'b0;
    logic pin6  = 1'b0;
    logic pin7  = 1'b0;
    logic pin9  = 1'b0;
    logic pin10 = 1'b0;
    logic pin15, pin14, pin13, pin12;
`ifdef HC194_PWR_PINS_EN
    logic pin8, pin16;
`endif

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    int model = 0;

    sn74hc194_shift #(.CLR_VALUE(CLR)) dut (
        .pin11(pin11), .pin1(pin1), .pin2(pin2), .pin3(pin3), .pin4(pin4),
        .pin5(pin5), .pin6(pin6), .pin7(pin7), .pin9(pin9), .pin10(pin10),
        .pin15(pin15), .pin14(pin14), .pin13(pin13), .pin12(pin12)
`ifdef HC194_PWR_PINS_EN
        , .pin8(pin8), .pin16(pin16)
`endif
    );

    // Clock/reset
    always #5 pin11 = ~pin11;

    function automatic logic [3:0] q_out();
        return {pin15, pin14, pin13, pin12};
    endfunction

    // Behavioural model: register held as an integer 0..15, QA is weight 8.
    always @(posedge pin11 or negedge pin1) begin
        if (!pin1) begin
            model = int'(CLR);
        end else begin
            case ({pin10, pin9})
                2'b01:   model = (model / 2) + (pin2 ? 8 : 0);
                2'b10:   model = ((model * 2) % 16) + (pin7 ? 1 : 0);
                2'b11:   model = (pin3 ? 8 : 0) + (pin4 ? 4 : 0) + (pin5 ? 2 : 0) + (pin6 ? 1 : 0);
                default: model = model;
            endcase
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare on the inactive clock edge.
    always @(negedge pin11) begin
        if (cmp_en) begin
            chk("model", q_out(), 4'(model));
`ifdef HC194_PWR_PINS_EN
            checks++;
            if (pin8 !== 1'b0 || pin16 !== 1'b1) begin
                errors++;
                $display("FAIL pwr_pins: got pin8=%b pin16=%b expected 0 1", pin8, pin16);
            end
`endif
        end
    end

    // Driver tasks
    task automatic drive(input logic [1:0] s, input logic [3:0] abcd, input logic sr, input logic sl);
        {pin10, pin9} = s;
        {pin3, pin4, pin5, pin6} = abcd;
        pin2 = sr;
        pin7 = sl;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pin11);
        #1;
    endtask

    initial begin
        // 1. Reset
        drive(2'b00, 4'b0000, 1'b0, 1'b0);
        #12;
        chk("reset_initial", q_out(), CLR);
        pin1 = 1'b1;
        cmp_en = 1'b1;
        tick(1);
        drive(2'b11, 4'b1011, 1'b0, 1'b0);
        tick(1);
        chk("preload_1011", q_out(), 4'b1011);
        #2;
        pin1 = 1'b0;
        #1;
        chk("async_clear", q_out(), 4'b0000);
        drive(2'b11, 4'b1111, 1'b0, 1'b0);
        tick(2);
        chk("clear_holds", q_out(), 4'b0000);

        // 2. Parallel load then hold
        pin1 = 1'b1;
        drive(2'b11, 4'b1010, 1'b0, 1'b0);
        tick(1);
        chk("load_1010", q_out(), 4'b1010);
        drive(2'b00, 4'b0101, 1'b0, 1'b0);
        tick(3);
        chk("hold_1010", q_out(), 4'b1010);

        // 3. Shift right
        drive(2'b11, 4'b0000, 1'b0, 1'b0);
        tick(1);
        begin
            logic [3:0] sr_seq [5] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101, 4'b0110};
            logic       sr_in  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 5; i++) begin
                drive(2'b01, 4'b0000, sr_in[i], 1'b0);
                tick(1);
                chk($sformatf("shr_%0d", i), q_out(), sr_seq[i]);
            end
        end

        // 4. Shift left
        drive(2'b11, 4'b0000, 1'b0, 1'b0);
        tick(1);
        begin
            logic [3:0] sl_seq [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
            for (int i = 0; i < 5; i++) begin
                drive(2'b10, 4'b0000, 1'b0, (i < 4));
                tick(1);
                chk($sformatf("shl_%0d", i), q_out(), sl_seq[i]);
            end
        end

        // 5. Clear coincident with a clock edge
        drive(2'b11, 4'b1111, 1'b0, 1'b0);
        tick(1);
        chk("load_1111", q_out(), 4'b1111);
        drive(2'b11, 4'b0110, 1'b0, 1'b0);
        @(posedge pin11);
        pin1 = 1'b0;
        #1;
        chk("clear_wins", q_out(), 4'b0000);
        #2;
        pin1 = 1'b1;
        tick(1);
        chk("load_after_clear", q_out(), 4'b0110);

        // 6. Mode glitches between edges do not act
        drive(2'b11, 4'b0000, 1'b0, 1'b0);
        tick(1);
        drive(2'b01, 4'b0000, 1'b1, 1'b0);
        #1;
        {pin10, pin9} = 2'b10;
        #1;
        {pin10, pin9} = 2'b01;
        tick(1);
        chk("single_shift", q_out(), 4'b1000);
        drive(2'b00, 4'b0000, 1'b0, 1'b0);
        tick(2);
        chk("final_hold", q_out(), 4'b1000);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
